rom_access_scheduler: RTL and testbench

- Sits in front of the 16x4 parity-protected ROM.
- Shares the ROM's single registered read port between two host requesters using round-robin arbitration.
- Runs a background parity scrub over all 16 locations whenever the hosts are idle.
- Accumulates parity-error statistics and raises a sticky error interrupt.

---
 rtl/rom_access_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_rom_access_scheduler.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_access_scheduler.sv
// Two-host round-robin scheduler for the 16x4 parity ROM with idle-time
// parity scrub, saturating error statistics and a sticky error interrupt.
//
// Ports:
//   clk, reset            clock, async active-high reset
//   req*/addr*            host read requests (held until granted)
//   gnt*                  request accepted this cycle
//   rvalid*/rdata*/rerr*  response one cycle after gnt
//   rom_en/rom_addr       ROM read port (registered data returns next cycle)
//   rom_data/rom_perr     ROM registered data and parity error
//   scrub_en              allow background scrubbing
//   scrub_busy            scrub read issued this cycle
//   scrub_done            response for last address of a scrub pass checked
//   err_clr               clear err_count and err_irq
//   err_count             saturating parity error count
//   last_err_addr         address of the most recent errored read
//   err_irq               sticky parity error interrupt
module rom_access_scheduler #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 4,
    parameter int SCRUB_IDLE = 8,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [ADDR_W-1:0]    addr0,
    input  logic [ADDR_W-1:0]    addr1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 rvalid0,
    output logic                 rvalid1,
    output logic [DATA_W-1:0]    rdata0,
    output logic [DATA_W-1:0]    rdata1,
    output logic                 rerr0,
    output logic                 rerr1,
    output logic                 rom_en,
    output logic [ADDR_W-1:0]    rom_addr,
    input  logic [DATA_W-1:0]    rom_data,
    input  logic                 rom_perr,
    input  logic                 scrub_en,
    output logic                 scrub_busy,
    output logic                 scrub_done,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [ADDR_W-1:0]    last_err_addr,
    output logic                 err_irq
);

    localparam int IDLE_W = $clog2(SCRUB_IDLE + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(SCRUB_IDLE);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    // Owner of the read currently returning from the ROM.
    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_H0,
        TAG_H1,
        TAG_SCRUB
    } tag_t;

    tag_t tag_q, tag_d;

    // rr_q=0 favours req0 on a contested cycle.
    logic                 rr_q, rr_d;
    logic [IDLE_W-1:0]    idle_q, idle_d;
    logic [ADDR_W-1:0]    sptr_q, sptr_d;
    logic [ADDR_W-1:0]    addr_q;
    logic [ADDR_W-1:0]    resp_addr_q;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0]    lea_q, lea_d;
    logic                 irq_q, irq_d;

    logic pick0, pick1, scrub_go, resp_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_q       <= TAG_NONE;
            rr_q        <= 1'b0;
            idle_q      <= '0;
            sptr_q      <= '0;
            addr_q      <= '0;
            resp_addr_q <= '0;
            cnt_q       <= '0;
            lea_q       <= '0;
            irq_q       <= 1'b0;
        end else begin
            tag_q       <= tag_d;
            rr_q        <= rr_d;
            idle_q      <= idle_d;
            sptr_q      <= sptr_d;
            addr_q      <= rom_addr;
            resp_addr_q <= rom_addr;
            cnt_q       <= cnt_d;
            lea_q       <= lea_d;
            irq_q       <= irq_d;
        end
    end

    always_comb begin
        pick0    = 1'b0;
        pick1    = 1'b0;
        scrub_go = 1'b0;
        rr_d     = rr_q;
        tag_d    = TAG_NONE;
        rom_en   = 1'b0;
        rom_addr = addr_q;
        idle_d   = idle_q;
        sptr_d   = sptr_q;

        if (req0 && req1) begin
            pick0 = !rr_q;
            pick1 = rr_q;
            rr_d  = !rr_q;
        end else if (req0) begin
            pick0 = 1'b1;
        end else if (req1) begin
            pick1 = 1'b1;
        end else if (scrub_en && idle_q == IDLE_MAX) begin
            scrub_go = 1'b1;
        end

        if (pick0) begin
            rom_en   = 1'b1;
            rom_addr = addr0;
            tag_d    = TAG_H0;
        end else if (pick1) begin
            rom_en   = 1'b1;
            rom_addr = addr1;
            tag_d    = TAG_H1;
        end else if (scrub_go) begin
            rom_en   = 1'b1;
            rom_addr = sptr_q;
            tag_d    = TAG_SCRUB;
            sptr_d   = sptr_q + 1'b1;
        end

        // Any host activity or scrub disable restarts the idle window.
        if (req0 || req1 || !scrub_en) begin
            idle_d = '0;
        end else if (idle_q != IDLE_MAX) begin
            idle_d = idle_q + IDLE_W'(1);
        end
    end

    assign resp_err = (tag_q != TAG_NONE) && rom_perr;

    // An error in the same cycle as err_clr takes priority.
    always_comb begin
        cnt_d = cnt_q;
        lea_d = lea_q;
        irq_d = irq_q;
        if (resp_err) begin
            lea_d = resp_addr_q;
            irq_d = 1'b1;
            if (err_clr) begin
                cnt_d = ERR_CNT_W'(1);
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (err_clr) begin
            cnt_d = '0;
            irq_d = 1'b0;
        end
    end

    assign gnt0       = pick0;
    assign gnt1       = pick1;
    assign scrub_busy = scrub_go;

    // rom_data is X while the ROM is idle, so only pass it when owned.
    assign rvalid0 = (tag_q == TAG_H0);
    assign rvalid1 = (tag_q == TAG_H1);
    assign rdata0  = rvalid0 ? rom_data : '0;
    assign rdata1  = rvalid1 ? rom_data : '0;
    assign rerr0   = rvalid0 & rom_perr;
    assign rerr1   = rvalid1 & rom_perr;

    assign scrub_done = (tag_q == TAG_SCRUB) && (resp_addr_q == LAST_ADDR);

    assign err_count     = cnt_q;
    assign last_err_addr = lea_q;
    assign err_irq       = irq_q;

endmodule

// File: tb/tb_rom_access_scheduler.sv
// Testbench for rom_access_scheduler: ROM model, behavioural reference
// model compared every cycle, directed scenarios and randomized traffic.
module tb_rom_access_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic [3:0] addr0, addr1;
    logic       gnt0, gnt1, rvalid0, rvalid1, rerr0, rerr1;
    logic [3:0] rdata0, rdata1;
    logic       rom_en;
    logic [3:0] rom_addr;
    logic [3:0] rom_data;
    logic       rom_perr;
    logic       scrub_en, scrub_busy, scrub_done, err_clr;
    logic [7:0] err_count;
    logic [3:0] last_err_addr;
    logic       err_irq;

    logic       s_gnt0, s_gnt1, s_rvalid0, s_rvalid1, s_rerr0, s_rerr1;
    logic [3:0] s_rdata0, s_rdata1, s_rom_addr, s_lea;
    logic       s_rom_en, s_busy, s_done, s_irq;
    logic [1:0] s_err_count;

    always #5 clk = ~clk;

    rom_access_scheduler u_dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .rerr0(rerr0), .rerr1(rerr1),
        .rom_en(rom_en), .rom_addr(rom_addr),
        .rom_data(rom_data), .rom_perr(rom_perr),
        .scrub_en(scrub_en), .scrub_busy(scrub_busy),
        .scrub_done(scrub_done), .err_clr(err_clr),
        .err_count(err_count), .last_err_addr(last_err_addr),
        .err_irq(err_irq)
    );

    rom_access_scheduler #(.ERR_CNT_W(2)) u_sat (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .gnt0(s_gnt0), .gnt1(s_gnt1),
        .rvalid0(s_rvalid0), .rvalid1(s_rvalid1),
        .rdata0(s_rdata0), .rdata1(s_rdata1),
        .rerr0(s_rerr0), .rerr1(s_rerr1),
        .rom_en(s_rom_en), .rom_addr(s_rom_addr),
        .rom_data(rom_data), .rom_perr(rom_perr),
        .scrub_en(scrub_en), .scrub_busy(s_busy),
        .scrub_done(s_done), .err_clr(err_clr),
        .err_count(s_err_count), .last_err_addr(s_lea),
        .err_irq(s_irq)
    );

    int errors = 0;
    int checks = 0;

    logic [3:0] rom [16];
    logic       perr_m [16];
    logic [3:0] rom_q_next;
    logic       perr_next;

    // Reference state: pending owner 0 none,1 host0,2 host1,3 scrub.
    int m_pend, m_paddr, m_fav, m_idle, m_sptr, m_last;
    int m_cnt, m_cnt2, m_lea, m_irq;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {29'd0, gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
                rerr0, rerr1, rom_en, rom_addr, scrub_busy, scrub_done,
                err_count, last_err_addr, err_irq};
    endfunction

    always @(posedge clk) begin
        rom_data <= rom_q_next;
        rom_perr <= perr_next;
    end

    always @(negedge clk) begin
        int w, ea;
        bit e;
        if (rom_en) begin
            rom_q_next = rom[rom_addr];
            perr_next  = perr_m[rom_addr];
        end else begin
            rom_q_next = 'x;
            perr_next  = 'x;
        end
        if (reset) begin
            m_pend = 0; m_paddr = 0; m_fav = 0; m_idle = 0;
            m_sptr = 0; m_last = 0; m_cnt = 0; m_cnt2 = 0;
            m_lea = 0; m_irq = 0;
            chk("reset_outputs", all_outs(), 64'd0);
            chk("reset_sat_count", 64'(s_err_count), 64'd0);
        end else begin
            w = -1;
            if (req0 && req1)            w = m_fav;
            else if (req0)               w = 0;
            else if (req1)               w = 1;
            else if (scrub_en && m_idle == 8) w = 2;
            ea = (w == 0) ? int'(addr0) : (w == 1) ? int'(addr1) :
                 (w == 2) ? m_sptr : m_last;
            chk("gnt0", 64'(gnt0), 64'(w == 0));
            chk("gnt1", 64'(gnt1), 64'(w == 1));
            chk("scrub_busy", 64'(scrub_busy), 64'(w == 2));
            chk("rom_en", 64'(rom_en), 64'(w >= 0));
            chk("rom_addr", 64'(rom_addr), 64'(ea));
            chk("rvalid0", 64'(rvalid0), 64'(m_pend == 1));
            chk("rvalid1", 64'(rvalid1), 64'(m_pend == 2));
            if (m_pend == 1) begin
                chk("rdata0", 64'(rdata0), 64'(rom[m_paddr]));
                chk("rerr0", 64'(rerr0), 64'(perr_m[m_paddr]));
            end
            if (m_pend == 2) begin
                chk("rdata1", 64'(rdata1), 64'(rom[m_paddr]));
                chk("rerr1", 64'(rerr1), 64'(perr_m[m_paddr]));
            end
            chk("scrub_done", 64'(scrub_done),
                64'(m_pend == 3 && m_paddr == 15));
            chk("err_count", 64'(err_count), 64'(m_cnt));
            chk("last_err_addr", 64'(last_err_addr), 64'(m_lea));
            chk("err_irq", 64'(err_irq), 64'(m_irq));
            chk("sat_err_count", 64'(s_err_count), 64'(m_cnt2));

            e = (m_pend != 0) && perr_m[m_paddr];
            if (e) begin
                m_cnt  = err_clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
                m_cnt2 = err_clr ? 1 : ((m_cnt2 < 3) ? m_cnt2 + 1 : 3);
                m_lea  = m_paddr;
                m_irq  = 1;
            end else if (err_clr) begin
                m_cnt = 0; m_cnt2 = 0; m_irq = 0;
            end
            if (req0 && req1) m_fav = 1 - m_fav;
            if (req0 || req1 || !scrub_en) m_idle = 0;
            else if (m_idle < 8)          m_idle = m_idle + 1;
            if (w == 2) m_sptr = (m_sptr + 1) % 16;
            m_pend  = w + 1;
            m_paddr = ea;
            m_last  = ea;
        end
    end

    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        scrub_en = 1'b0; err_clr = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found, g0, g1, busy;
        reset = 1'b1;
        req0 = 0; req1 = 0; addr0 = 0; addr1 = 0;
        scrub_en = 0; err_clr = 0;
        for (int i = 0; i < 16; i++) begin
            rom[i]    = 4'($urandom);
            perr_m[i] = 1'b0;
        end
        rom[2] = 4'b1110;
        rom[9] = 4'b0010;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Contested grant
        req0 = 1; addr0 = 4'd2; req1 = 1; addr1 = 4'd9;
        @(negedge clk);
        chk("cont_gnt0", 64'(gnt0), 64'd1);
        chk("cont_gnt1_t0", 64'(gnt1), 64'd0);
        nx(); req0 = 0;
        @(negedge clk);
        chk("cont_gnt1", 64'(gnt1), 64'd1);
        chk("cont_rvalid0", 64'(rvalid0), 64'd1);
        chk("cont_rdata0", 64'(rdata0), 64'b1110);
        chk("cont_rerr0", 64'(rerr0), 64'd0);
        nx(); req1 = 0;
        @(negedge clk);
        chk("cont_rvalid1", 64'(rvalid1), 64'd1);
        chk("cont_rdata1", 64'(rdata1), 64'b0010);
        chk("cont_rerr1", 64'(rerr1), 64'd0);
        nx();

        // Round-robin fairness
        do_reset();
        req0 = 1; req1 = 1; addr0 = 4'd1; addr1 = 4'd4;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rr_gnt0", 64'(gnt0), 64'(i % 2 == 0));
            chk("rr_gnt1", 64'(gnt1), 64'(i % 2 == 1));
            if (i > 0) chk("rr_rvalid0", 64'(rvalid0), 64'(i % 2 == 1));
            nx();
        end
        req0 = 0; req1 = 0;

        // Scrub pass and wrap
        do_reset();
        scrub_en = 1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (i < 8) begin
                chk("scrub_wait", 64'(scrub_busy), 64'd0);
            end else if (i < 24) begin
                chk("scrub_busy", 64'(scrub_busy), 64'd1);
                chk("scrub_addr", 64'(rom_addr), 64'(i - 8));
            end else begin
                chk("scrub_done_pulse", 64'(scrub_done), 64'd1);
                chk("scrub_wrap", 64'(rom_addr), 64'd0);
            end
            nx();
        end

        // Preemption at scrub pointer 6
        repeat (5) nx();
        req1 = 1; addr1 = 4'd3;
        @(negedge clk);
        chk("pre_gnt1", 64'(gnt1), 64'd1);
        chk("pre_no_scrub", 64'(scrub_busy), 64'd0);
        chk("pre_addr", 64'(rom_addr), 64'd3);
        nx(); req1 = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i < 8) begin
                chk("pre_idle", 64'(scrub_busy), 64'd0);
            end else begin
                chk("pre_resume", 64'(scrub_busy), 64'd1);
                chk("pre_resume_addr", 64'(rom_addr), 64'd6);
            end
            nx();
        end
        scrub_en = 0;

        // Error logging
        do_reset();
        perr_m[5] = 1'b1;
        req0 = 1; addr0 = 4'd5;
        @(negedge clk);
        nx(); req0 = 0;
        @(negedge clk);
        chk("err_rerr0", 64'(rerr0), 64'd1);
        nx();
        scrub_en = 1;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (scrub_done) found = 1;
            nx();
        end
        chk("err_scrub_done_seen", 64'(found), 64'd1);
        scrub_en = 0;
        @(negedge clk);
        chk("err_count2", 64'(err_count), 64'd2);
        chk("err_lea5", 64'(last_err_addr), 64'd5);
        chk("err_irq1", 64'(err_irq), 64'd1);
        nx();

        // err_clr colliding with an errored response
        req0 = 1; addr0 = 4'd5;
        @(negedge clk);
        nx(); req0 = 0; err_clr = 1;
        @(negedge clk);
        nx(); err_clr = 0;
        @(negedge clk);
        chk("clr_coll_count", 64'(err_count), 64'd1);
        chk("clr_coll_irq", 64'(err_irq), 64'd1);
        nx(); err_clr = 1;
        @(negedge clk);
        nx(); err_clr = 0;
        @(negedge clk);
        chk("clr_count", 64'(err_count), 64'd0);
        chk("clr_irq", 64'(err_irq), 64'd0);
        chk("clr_keeps_lea", 64'(last_err_addr), 64'd5);
        nx();

        // Reset during a pending response
        req0 = 1; addr0 = 4'd2;
        @(negedge clk);
        chk("rst_gnt0", 64'(gnt0), 64'd1);
        @(posedge clk);
        #1 reset = 1; req0 = 0;
        @(negedge clk);
        chk("rst_no_rvalid", 64'(rvalid0), 64'd0);
        chk("rst_all_zero", all_outs(), 64'd0);
        @(posedge clk);
        #1 reset = 0;

        // Saturation of the narrow counter
        req0 = 1; addr0 = 4'd5;
        repeat (5) nx();
        req0 = 0;
        @(negedge clk);
        nx();
        @(negedge clk);
        chk("sat_main5", 64'(err_count), 64'd5);
        chk("sat_narrow3", 64'(s_err_count), 64'd3);
        nx();

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 16; i++) begin
            rom[i]    = 4'($urandom);
            perr_m[i] = ($urandom_range(3) == 0);
        end
        scrub_en = 1; busy = 0;
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            g0 = gnt0; g1 = gnt1;
            nx();
            if (c % 100 == 0) busy = $urandom_range(1);
            if (req0 && g0) req0 = 0;
            if (req1 && g1) req1 = 0;
            if (!req0 && (busy ? $urandom_range(1) == 0
                               : $urandom_range(29) == 0)) begin
                req0 = 1; addr0 = 4'($urandom);
            end
            if (!req1 && (busy ? $urandom_range(1) == 0
                               : $urandom_range(29) == 0)) begin
                req1 = 1; addr1 = 4'($urandom);
            end
            if ($urandom_range(59) == 0) scrub_en = ~scrub_en;
            err_clr = ($urandom_range(39) == 0);
        end
        req0 = 0; req1 = 0; err_clr = 0;
        repeat (3) nx();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
